// File: rtl/instr_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : instr_stream_ctrl
//  Description : Instruction stream controller. Collects a short program into
//                an on-chip buffer while idle, then streams it word-by-word to
//                a processor. The processor can stall the stream. One cycle
//                after each accepted word, the processor result (data_out) is
//                folded into a rotate-xor signature.
//
//  Ports
//    clk          : single clock, rising edge
//    reset        : asynchronous, active-low reset
//    load_valid   : load_data valid this cycle
//    load_data    : program word to append to the buffer
//    load_ready   : buffer accepts a load this cycle (IDLE and not full)
//    start        : pulse, begins streaming from IDLE
//    clear        : return to IDLE and empty the buffer (highest priority)
//    proc_stall   : processor not accepting; hold the current instruction
//    instruction  : word presented to the processor (NOP_WORD when invalid)
//    instr_valid  : instruction carries a program word
//    data_out     : processor result, sampled one cycle after each issue
//    signature    : running result signature
//    issued_count : instructions issued since start
//    busy         : RUN or DRAIN
//    done         : DONE reached
//
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_stream_ctrl #(
  parameter int unsigned DEPTH    = 16,
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  input  logic        start,
  input  logic        clear,
  input  logic        proc_stall,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic [31:0] data_out,
  output logic [31:0] signature,
  output logic [8:0]  issued_count,
  output logic        busy,
  output logic        done
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   prog_len_q, prog_len_d;   // 0..DEPTH, one extra bit for "full"
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [8:0]    issued_q, issued_d;
  logic [31:0]   sig_q, sig_d;
  logic          cap_q, cap_d;             // an issue happened last cycle
  logic          instr_valid_q, instr_valid_d;
  logic [31:0]   instruction_q, instruction_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          load_ready_q, load_ready_d;

  logic          load_fire;
  logic          is_last;

  // Program buffer. Deliberately not reset: prog_len alone defines which
  // entries are meaningful.
  logic [31:0]   mem_q [DEPTH];

  assign is_last = ({1'b0, rd_ptr_q} == (prog_len_q - 1'b1));

  always_comb begin
    state_d    = state_q;
    prog_len_d = prog_len_q;
    rd_ptr_d   = rd_ptr_q;
    issued_d   = issued_q;
    sig_d      = sig_q;
    cap_d      = 1'b0;
    load_fire  = 1'b0;

    // Fold in the result of the word issued on the previous edge. This runs
    // in RUN (after a non-final issue) and in DRAIN (the final issue).
    if (cap_q) begin
      sig_d = {sig_q[30:0], sig_q[31]} ^ data_out;
    end

    case (state_q)
      S_IDLE: begin
        if (load_valid && load_ready_q) begin
          load_fire  = 1'b1;
          prog_len_d = prog_len_q + 1'b1;
        end
        if (start) begin
          rd_ptr_d = '0;
          issued_d = '0;
          sig_d    = '0;
          state_d  = (prog_len_q != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (!proc_stall) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          issued_d = issued_q + 9'd1;
          cap_d    = 1'b1;
          if (is_last) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // clear overrides start and load issued in the same cycle.
    if (clear) begin
      state_d    = S_IDLE;
      prog_len_d = '0;
      rd_ptr_d   = '0;
      issued_d   = '0;
      sig_d      = '0;
      cap_d      = 1'b0;
      load_fire  = 1'b0;
    end
  end

  // Outputs are registered: they are decoded from the next-state values so
  // that they line up with the state they describe.
  always_comb begin
    instr_valid_d = (state_d == S_RUN);
    instruction_d = (state_d == S_RUN) ? mem_q[rd_ptr_d] : NOP_WORD;
    busy_d        = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d        = (state_d == S_DONE);
    // DEPTH is a power of two, so the top bit of prog_len marks "full".
    load_ready_d  = (state_d == S_IDLE) && !prog_len_d[AW];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      prog_len_q    <= '0;
      rd_ptr_q      <= '0;
      issued_q      <= '0;
      sig_q         <= '0;
      cap_q         <= 1'b0;
      instr_valid_q <= 1'b0;
      instruction_q <= NOP_WORD;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      load_ready_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      prog_len_q    <= prog_len_d;
      rd_ptr_q      <= rd_ptr_d;
      issued_q      <= issued_d;
      sig_q         <= sig_d;
      cap_q         <= cap_d;
      instr_valid_q <= instr_valid_d;
      instruction_q <= instruction_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      load_ready_q  <= load_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) begin
      mem_q[prog_len_q[AW-1:0]] <= load_data;
    end
  end

  assign load_ready   = load_ready_q;
  assign instruction  = instruction_q;
  assign instr_valid  = instr_valid_q;
  assign signature    = sig_q;
  assign issued_count = issued_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
`default_nettype wire

// File: doc/instr_stream_ctrl.md
INSTR_STREAM_CTRL -- requirements
Module: instr_stream_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16: program buffer entries (power of 2, 2..256).
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000013: word driven on instruction when not issuing.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset; 0 resets all state immediately.
REQ-005 SHALL have port load_valid, input, 1: load_data is valid this cycle.
REQ-006 SHALL have port load_data, input, 32: instruction word to append to the program buffer.
REQ-007 SHALL have port load_ready, output, 1: buffer accepts a load this cycle.
REQ-008 SHALL have port start, input, 1: single-cycle pulse that begins streaming.
REQ-009 SHALL have port clear, input, 1: returns to IDLE and empties the buffer.
REQ-010 SHALL have port proc_stall, input, 1: processor not accepting; hold current instruction.
REQ-011 SHALL have port instruction, output, 32: word presented to the processor.
REQ-012 SHALL have port instr_valid, output, 1: instruction carries a program word.
REQ-013 SHALL have port data_out, input, 32: processor result, sampled one cycle after each issue.
REQ-014 SHALL have port signature, output, 32: running result signature.
REQ-015 SHALL have port issued_count, output, 9: number of instructions issued since start.
REQ-016 SHALL have ports busy and done, output, 1 each: RUN/DRAIN active; DONE reached.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE; busy=1 only in RUN/DRAIN; done=1 only in DONE.
REQ-018 In IDLE, load_ready SHALL equal (prog_len < DEPTH); otherwise load_ready=0.
REQ-019 Load (load_valid && load_ready) SHALL write load_data at index prog_len and increment prog_len by 1.
REQ-020 load_valid with load_ready=0 (full, or not IDLE) SHALL be ignored; no state change.
REQ-021 start in IDLE with prog_len>0 SHALL enter RUN next cycle, reset rd_ptr, issued_count and signature to 0.
REQ-022 start in IDLE with prog_len=0 SHALL go directly to DONE with signature=0.
REQ-023 start in RUN, DRAIN or DONE SHALL be ignored.
REQ-024 In RUN: instr_valid=1, instruction=buffer[rd_ptr]; an issue occurs when proc_stall=0.
REQ-025 On issue: rd_ptr and issued_count SHALL increment by 1; if rd_ptr=prog_len-1, next state SHALL be DRAIN.
REQ-026 With proc_stall=1 in RUN: instruction, rd_ptr and issued_count SHALL hold.
REQ-027 Capture: in the cycle after each issue, signature SHALL update to {signature[30:0],signature[31]} ^ data_out.
REQ-028 DRAIN SHALL last exactly one cycle (final capture), then enter DONE regardless of proc_stall.
REQ-029 When instr_valid=0, instruction SHALL equal NOP_WORD.
REQ-030 DONE SHALL hold signature and issued_count until clear or reset.
REQ-031 clear in any state SHALL next cycle enter IDLE, set prog_len, rd_ptr, issued_count and signature to 0; clear takes priority over start and load in the same cycle.
REQ-032 Buffer contents are NOT cleared by clear or reset; only prog_len defines valid entries.
REQ-033 Latency: first issue available the cycle after start is accepted; N instructions without stall reach DONE N+2 cycles after start.

Reset
REQ-034 On reset=0: state=IDLE, prog_len=0, rd_ptr=0, issued_count=0, signature=0, instr_valid=0, instruction=NOP_WORD, busy=0, done=0, load_ready=1.
REQ-035 Reset asserted mid-RUN SHALL abort immediately with no further capture; streaming restarts only after reload and start.

Verification
REQ-036 Load 2 words 0x00500093, 0x00A00113; start; no stall; data_out=0x00000001 then 0x00000010 -> issues in 2 consecutive cycles, DONE after 4 cycles, signature=0x00000012, issued_count=2.
REQ-037 Load 3 words; start; proc_stall=1 for 3 cycles at the 2nd word -> 2nd word held 4 cycles, issued_count=3, DONE 8 cycles after start.
REQ-038 Load DEPTH=16 words, then attempt a 17th -> load_ready=0 after the 16th, 17th ignored, prog_len=16, RUN issues exactly 16.
REQ-039 start with empty buffer -> DONE next cycle, signature=0, issued_count=0, instr_valid never 1.
REQ-040 reset=0 during RUN after 1 issue -> outputs at REQ-034 values asynchronously; clear in DONE -> IDLE, load_ready=1, signature=0.
REQ-041 start during RUN and load_valid during RUN -> ignored; issued_count and prog_len unchanged.
